// File: rtl/btp_pkg.sv
// ============================================================================
// btp_pkg : shared types, counter encodings and counter helpers for the BTB.
// Revision 1.0
// ============================================================================
`default_nettype none

package btp_pkg;

   // Configuration the predictor ships with.
   localparam int BTP_DEF_ENTRIES = 64;
   localparam int BTP_DEF_TAG_W   = 8;
   localparam int BTP_DEF_CNT_W   = 2;
   localparam int BTP_DEF_PC_W    = 32;

   // Widest counter the helpers below can handle.
   localparam int CNT_MAX_W = 8;
   typedef logic [CNT_MAX_W-1:0] cnt_t;

   // Two-bit counter encodings.
   localparam logic [1:0] CNT2_STRONG_NT = 2'd0;
   localparam logic [1:0] CNT2_WEAK_NT   = 2'd1;
   localparam logic [1:0] CNT2_WEAK_T    = 2'd2;
   localparam logic [1:0] CNT2_STRONG_T  = 2'd3;
   localparam logic [1:0] CNT2_INIT      = CNT2_WEAK_T;

   // Entry layout for the shipping configuration.
   typedef struct packed {
      logic                     valid;
      logic [BTP_DEF_TAG_W-1:0] tag;
      logic [BTP_DEF_PC_W-1:0]  target;
      logic [BTP_DEF_CNT_W-1:0] cnt;
   } btp_entry_t;

   function automatic cnt_t cnt_top(input int w);
      return cnt_t'((1 << w) - 1);
   endfunction

   function automatic cnt_t cnt_weak_taken(input int w);
      return cnt_t'(1) << (w - 1);
   endfunction

   function automatic cnt_t sat_inc(input cnt_t c, input int w);
      return (c == cnt_top(w)) ? c : c + cnt_t'(1);
   endfunction

   function automatic cnt_t sat_dec(input cnt_t c);
      return (c == '0) ? c : c - cnt_t'(1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/btp_entry_array.sv
// ============================================================================
// btp_entry_array : BTB storage, one combinational read port, one synchronous
// write port; only the valid vector is reset.  Revision 1.0
// ============================================================================
`default_nettype none

module btp_entry_array
   import btp_pkg::*;
#(
   parameter int ENTRIES = BTP_DEF_ENTRIES,
   parameter int TAG_W   = BTP_DEF_TAG_W,
   parameter int CNT_W   = BTP_DEF_CNT_W,
   parameter int PC_W    = BTP_DEF_PC_W,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_valid,
   output logic [TAG_W-1:0] rd_tag,
   output logic [PC_W-1:0]  rd_target,
   output logic [CNT_W-1:0] rd_cnt,
   input  logic             wr_en,
   input  logic             set_valid,
   input  logic             clr_valid,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic [PC_W-1:0]  wr_target,
   input  logic [CNT_W-1:0] wr_cnt
);

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [PC_W-1:0]  target;
      logic [CNT_W-1:0] cnt;
   } slot_t;

   slot_t              mem [ENTRIES];
   logic [ENTRIES-1:0] valid;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= '{tag: wr_tag, target: wr_target, cnt: wr_cnt};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid <= '0;
      end else if (set_valid) begin
         valid[wr_idx] <= 1'b1;
      end else if (clr_valid) begin
         valid[wr_idx] <= 1'b0;
      end
   end

   // No write-to-read bypass: a same-index lookup sees the old entry.
   assign rd_valid  = valid[rd_idx];
   assign rd_tag    = mem[rd_idx].tag;
   assign rd_target = mem[rd_idx].target;
   assign rd_cnt    = mem[rd_idx].cnt;

endmodule

`default_nettype wire

// File: rtl/branch_target_predictor.sv
// ============================================================================
// branch_target_predictor : direct-mapped BTB with saturating counters, IF
// lookup and ID resolve/train. Optional stats counters: BTP_STATS_EN. Rev 1.0
// ============================================================================
`default_nettype none

module branch_target_predictor
   import btp_pkg::*;
#(
   parameter int ENTRIES = BTP_DEF_ENTRIES,
   parameter int TAG_W   = BTP_DEF_TAG_W,
   parameter int CNT_W   = BTP_DEF_CNT_W,
   parameter int PC_W    = BTP_DEF_PC_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [PC_W-1:0] pc_if,
   input  logic            stall,
   output logic            pred_taken,
   output logic [PC_W-1:0] pred_target,
   output logic [PC_W-1:0] npc,
   input  logic            upd_valid,
   input  logic [PC_W-1:0] pc_id,
   input  logic            taken_id,
   input  logic [PC_W-1:0] target_id,
   output logic            fail,
   output logic [31:0]     lookups,
   output logic [31:0]     mispredicts
);

   localparam int              IDX_W    = $clog2(ENTRIES);
   localparam logic [PC_W-1:0] PC_STEP  = PC_W'(4);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_weak_taken(CNT_W));

   generate
      if ((1 << IDX_W) != ENTRIES || ENTRIES < 4 || IDX_W + TAG_W + 2 > PC_W ||
          CNT_W < 1 || CNT_W > CNT_MAX_W) begin : g_bad_params
         $error("branch_target_predictor: illegal parameter set");
      end
   endgenerate

   logic [IDX_W-1:0] idx_if, idx_id;
   logic [TAG_W-1:0] tag_if, tag_id;
   logic             rd_valid;
   logic [TAG_W-1:0] rd_tag;
   logic [PC_W-1:0]  rd_target;
   logic [CNT_W-1:0] rd_cnt;
   logic             hit_if;

   assign idx_if = pc_if[IDX_W+1:2];
   assign tag_if = pc_if[IDX_W+TAG_W+1:IDX_W+2];
   assign idx_id = pc_id[IDX_W+1:2];
   assign tag_id = pc_id[IDX_W+TAG_W+1:IDX_W+2];

   assign hit_if      = rd_valid && (rd_tag == tag_if);
   assign pred_taken  = hit_if && rd_cnt[CNT_W-1];
   assign pred_target = rd_target;

   // ID copy of the IF lookup; the counter rides along so training needs no
   // second read port.
   logic             id_pt, id_hit;
   logic [PC_W-1:0]  id_tgt;
   logic [CNT_W-1:0] id_cnt;
   logic             act;

   assign act  = upd_valid & taken_id;
   assign fail = ~stall & ((id_pt != act) | (id_pt & act & (id_tgt != target_id)));

   always_comb begin
      if (fail) begin
         npc = act ? target_id : pc_id + PC_STEP;
      end else if (pred_taken) begin
         npc = pred_target;
      end else begin
         npc = pc_if + PC_STEP;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || (!stall && fail)) begin
         id_pt  <= 1'b0;
         id_hit <= 1'b0;
         id_tgt <= '0;
         id_cnt <= '0;
      end else if (!stall) begin
         id_pt  <= pred_taken;
         id_hit <= hit_if;
         id_tgt <= rd_target;
         id_cnt <= rd_cnt;
      end
   end

   logic             train, wr_en, set_valid, clr_valid;
   logic [PC_W-1:0]  wr_target;
   logic [CNT_W-1:0] wr_cnt;

   assign train = rst & ~stall;

   always_comb begin
      wr_en     = 1'b0;
      set_valid = 1'b0;
      clr_valid = 1'b0;
      wr_target = target_id;
      wr_cnt    = id_cnt;
      if (train) begin
         if (upd_valid && taken_id) begin
            wr_en     = 1'b1;
            set_valid = 1'b1;
            wr_cnt    = id_hit ? CNT_W'(sat_inc(CNT_MAX_W'(id_cnt), CNT_W)) : CNT_INIT;
         end else if (upd_valid && id_hit) begin
            wr_en     = 1'b1;
            wr_target = id_tgt;
            wr_cnt    = CNT_W'(sat_dec(CNT_MAX_W'(id_cnt)));
         end else if (!upd_valid && id_hit && id_pt) begin
            // A non-branch aliased onto a taken entry: drop it.
            clr_valid = 1'b1;
         end
      end
   end

   btp_entry_array #(
      .ENTRIES (ENTRIES),
      .TAG_W   (TAG_W),
      .CNT_W   (CNT_W),
      .PC_W    (PC_W),
      .IDX_W   (IDX_W)
   ) u_array (
      .clk       (clk),
      .rst       (rst),
      .rd_idx    (idx_if),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_target (rd_target),
      .rd_cnt    (rd_cnt),
      .wr_en     (wr_en),
      .set_valid (set_valid),
      .clr_valid (clr_valid),
      .wr_idx    (idx_id),
      .wr_tag    (tag_id),
      .wr_target (wr_target),
      .wr_cnt    (wr_cnt)
   );

`ifdef BTP_STATS_EN
   logic [31:0] lookup_cnt, mispredict_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         lookup_cnt     <= '0;
         mispredict_cnt <= '0;
      end else begin
         if (!stall && lookup_cnt != '1) begin
            lookup_cnt <= lookup_cnt + 32'd1;
         end
         if (fail && mispredict_cnt != '1) begin
            mispredict_cnt <= mispredict_cnt + 32'd1;
         end
      end
   end

   assign lookups     = lookup_cnt;
   assign mispredicts = mispredict_cnt;
`else
   assign lookups     = '0;
   assign mispredicts = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
// ============================================================================
// tb_branch_target_predictor : directed test of branch_target_predictor.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_branch_target_predictor;

   localparam logic [31:0] OTHER = 32'h1000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] pc_if = '0;
   logic        stall = 1'b0;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic [31:0] npc;
   logic        upd_valid = 1'b0;
   logic [31:0] pc_id = '0;
   logic        taken_id = 1'b0;
   logic [31:0] target_id = '0;
   logic        fail;
   logic [31:0] lookups, mispredicts;

   int errors = 0;
   int checks = 0;
   logic [31:0] misp_before;

   always #5 clk = ~clk;

   branch_target_predictor #(
      .ENTRIES (64),
      .TAG_W   (8),
      .CNT_W   (2),
      .PC_W    (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_if       (pc_if),
      .stall       (stall),
      .pred_taken  (pred_taken),
      .pred_target (pred_target),
      .npc         (npc),
      .upd_valid   (upd_valid),
      .pc_id       (pc_id),
      .taken_id    (taken_id),
      .target_id   (target_id),
      .fail        (fail),
      .lookups     (lookups),
      .mispredicts (mispredicts)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Apply one cycle of inputs and settle to the falling edge for sampling.
   task automatic drive(input logic [31:0] pif, input logic stl, input logic uv,
                        input logic [31:0] pid, input logic tk, input logic [31:0] tgt);
      pc_if     = pif;
      stall     = stl;
      upd_valid = uv;
      pc_id     = pid;
      taken_id  = tk;
      target_id = tgt;
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lookup(input logic [31:0] pc);
      drive(pc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      drive(OTHER, 1'b0, 1'b1, pc, tk, tgt);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tick();
      tick();
      rst = 1'b1;

      // Reset state
      lookup(32'h100);
      check("rst_pred_taken", {31'b0, pred_taken}, 32'd0);
      check("rst_npc", npc, 32'h104);
      check("rst_fail", {31'b0, fail}, 32'd0);
      tick();

      // Cold taken branch allocates the entry
      resolve(32'h40, 1'b1, 32'h80);
      check("cold_fail", {31'b0, fail}, 32'd1);
      check("cold_npc", npc, 32'h80);
      tick();
      lookup(32'h40);
      check("alloc_pred_taken", {31'b0, pred_taken}, 32'd1);
      check("alloc_pred_target", pred_target, 32'h80);
      check("alloc_npc", npc, 32'h80);
      tick();

      // Three more takens saturate the counter at 3
      for (int i = 0; i < 3; i++) begin
         resolve(32'h40, 1'b1, 32'h80);
         check("train_t_fail", {31'b0, fail}, 32'd0);
         check("train_t_npc", npc, OTHER + 32'd4);
         tick();
         lookup(32'h40);
         check("train_t_pred", {31'b0, pred_taken}, 32'd1);
         tick();
      end

      // 3 -> 2 still predicts taken, 2 -> 1 predicts not-taken
      resolve(32'h40, 1'b0, 32'h0);
      check("nt1_fail", {31'b0, fail}, 32'd1);
      check("nt1_npc", npc, 32'h44);
      tick();
      lookup(32'h40);
      check("nt1_pred", {31'b0, pred_taken}, 32'd1);
      tick();
      resolve(32'h40, 1'b0, 32'h0);
      check("nt2_fail", {31'b0, fail}, 32'd1);
      check("nt2_npc", npc, 32'h44);
      tick();
      lookup(32'h40);
      check("nt2_pred", {31'b0, pred_taken}, 32'd0);
      check("nt2_lookup_npc", npc, 32'h44);
      tick();

      // Retrain to 2, then aliasing lookup at the same index misses
      resolve(32'h40, 1'b1, 32'h80);
      check("retrain_fail", {31'b0, fail}, 32'd1);
      check("retrain_npc", npc, 32'h80);
      tick();
      lookup(32'h140);
      check("alias_pred", {31'b0, pred_taken}, 32'd0);
      check("alias_npc", npc, 32'h144);
      tick();
      lookup(32'h40);
      check("retrain_pred", {31'b0, pred_taken}, 32'd1);
      tick();

      // Taken with a changed target mispredicts on the target alone
      resolve(32'h40, 1'b1, 32'hC0);
      check("tgt_fail", {31'b0, fail}, 32'd1);
      check("tgt_npc", npc, 32'hC0);
      tick();
      lookup(32'h40);
      check("tgt_pred_target", pred_target, 32'hC0);
      tick();

      // Stall: mispredicted branch held in ID for two cycles
      drive(OTHER, 1'b1, 1'b1, 32'h40, 1'b1, 32'h100);
      check("stall1_fail", {31'b0, fail}, 32'd0);
      tick();
      drive(32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h100);
      check("stall2_fail", {31'b0, fail}, 32'd0);
      check("stall2_table_target", pred_target, 32'hC0);
      check("stall2_table_pred", {31'b0, pred_taken}, 32'd1);
      tick();
      drive(OTHER, 1'b0, 1'b1, 32'h40, 1'b1, 32'h100);
      check("release_fail", {31'b0, fail}, 32'd1);
      check("release_npc", npc, 32'h100);
      tick();

      // Alias on a non-branch invalidates the entry
      lookup(32'h40);
      check("pre_alias_pred", {31'b0, pred_taken}, 32'd1);
      check("pre_alias_target", pred_target, 32'h100);
      misp_before = mispredicts;
      tick();
      drive(OTHER, 1'b0, 1'b0, 32'h40, 1'b0, 32'h0);
      check("nonbr_fail", {31'b0, fail}, 32'd1);
      check("nonbr_npc", npc, 32'h44);
      tick();
      lookup(32'h40);
      check("inval_pred", {31'b0, pred_taken}, 32'd0);
      check("inval_npc", npc, 32'h44);
`ifdef BTP_STATS_EN
      check("stats_mispredicts_inc", mispredicts, misp_before + 32'd1);
`endif
      tick();

      // Mid-operation reset beats training and clears the ID register
      resolve(32'h40, 1'b1, 32'h80);
      tick();
      lookup(32'h40);
      check("realloc_pred", {31'b0, pred_taken}, 32'd1);
      tick();
      rst = 1'b0;
      drive(OTHER, 1'b0, 1'b1, 32'h40, 1'b1, 32'hC0);
      tick();
      rst = 1'b1;
      drive(OTHER, 1'b0, 1'b0, 32'h40, 1'b0, 32'h0);
      check("post_rst_fail", {31'b0, fail}, 32'd0);
      check("post_rst_npc", npc, OTHER + 32'd4);
      check("post_rst_lookups", lookups, 32'd0);
      check("post_rst_mispredicts", mispredicts, 32'd0);
      tick();
      lookup(32'h40);
      check("post_rst_pred", {31'b0, pred_taken}, 32'd0);
      check("post_rst_lookup_npc", npc, 32'h44);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
